// File: rtl/boot_pkg.sv
// Shared constants for the UART boot loader: frame markers and FSM state encoding.
package boot_pkg;

   // Start marker as seen in the HUNT byte history (5a received first, newest byte in [7:0]).
   localparam logic [31:0] START_MARKER = 32'h5aa50ff0;
   // End marker as an assembled little-endian payload word (bytes f0 0f a5 5a).
   localparam logic [31:0] END_MARKER   = 32'h5aa50ff0;

   localparam int unsigned STATE_W = 2;

   localparam logic [STATE_W-1:0] ST_HUNT    = 2'd0;
   localparam logic [STATE_W-1:0] ST_PAYLOAD = 2'd1;
   localparam logic [STATE_W-1:0] ST_CHECK   = 2'd2;
   localparam logic [STATE_W-1:0] ST_DONE    = 2'd3;

endpackage

// File: rtl/boot_timeout_counter.sv
// Idle-cycle watchdog: counts enabled cycles since the last clear and flags expiry
// after TIMEOUT_CYCLES consecutive idle cycles.
module boot_timeout_counter #(
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear_i,
   input  logic en_i,
   output logic expired_o
);

   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic             expired_q;

   // Count idle cycles while enabled; saturate once expired.
   always_ff @(posedge clk) begin
      if (reset || clear_i || !en_i) begin
         cnt_q     <= '0;
         expired_q <= 1'b0;
      end else if (!expired_q) begin
         cnt_q     <= cnt_q + CNT_W'(1);
         expired_q <= (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
      end
   end

   assign expired_o = expired_q;

endmodule

// File: rtl/uart_boot_loader.sv
// UART boot loader: hunts for a start marker in the rx byte stream, assembles
// little-endian payload words and writes them to instruction flash until the
// end marker. Optional trailing XOR checksum when BOOT_CHECKSUM_EN is defined.
module uart_boot_loader
   import boot_pkg::*;
#(
   parameter int unsigned ADDR_W         = 10,
   parameter int unsigned TIMEOUT_CYCLES = 100000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              flash_wr_en,
   output logic [ADDR_W-1:0] flash_wr_addr,
   output logic [31:0]       flash_wr_data,
   output logic              busy,
   output logic              done,
   output logic              error,
   output logic [ADDR_W:0]   word_count
);

   localparam int unsigned WC_W = ADDR_W + 1;
   localparam logic [WC_W-1:0] CAPACITY = WC_W'(1) << ADDR_W;

   logic [STATE_W-1:0] state_q, state_d;
   logic [31:0]        hist_q, hist_d;
   logic [23:0]        word_q, word_d;
   logic [1:0]         idx_q, idx_d;
   logic [ADDR_W-1:0]  addr_q, addr_d;
   logic [WC_W-1:0]    wc_q, wc_d;
   logic               wr_en_q, wr_en_d;
   logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
   logic [31:0]        wr_data_q, wr_data_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               error_q, error_d;
`ifdef BOOT_CHECKSUM_EN
   logic [7:0]         csum_q, csum_d;
`endif

   logic [31:0] full_word;
   logic        tmo_expired;

   assign full_word = {rx_data, word_q};

   boot_timeout_counter #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk      (clk),
      .reset    (reset),
      .clear_i  (rx_valid),
      .en_i     ((state_q == ST_PAYLOAD) || (state_q == ST_CHECK)),
      .expired_o(tmo_expired)
   );

   // Next-state logic: marker hunt, byte assembly, write issue and abort handling.
   always_comb begin
      state_d   = state_q;
      hist_d    = hist_q;
      word_d    = word_q;
      idx_d     = idx_q;
      addr_d    = addr_q;
      wc_d      = wc_q;
      wr_en_d   = 1'b0;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      error_d   = error_q;
`ifdef BOOT_CHECKSUM_EN
      csum_d    = csum_q;
`endif
      case (state_q)
         ST_HUNT: begin
            if (rx_valid) begin
               hist_d = {hist_q[23:0], rx_data};
               if (hist_d == START_MARKER) begin
                  state_d = ST_PAYLOAD;
                  hist_d  = '0;
                  word_d  = '0;
                  idx_d   = '0;
                  addr_d  = '0;
                  wc_d    = '0;
                  error_d = 1'b0;
                  busy_d  = 1'b1;
`ifdef BOOT_CHECKSUM_EN
                  csum_d  = '0;
`endif
               end
            end
         end
         ST_PAYLOAD: begin
            if (tmo_expired) begin
               error_d = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_HUNT;
            end else if (rx_valid) begin
               idx_d = idx_q + 2'd1;
               case (idx_q)
                  2'd0: word_d[7:0]   = rx_data;
                  2'd1: word_d[15:8]  = rx_data;
                  2'd2: word_d[23:16] = rx_data;
                  default: begin
                     if (full_word == END_MARKER) begin
`ifdef BOOT_CHECKSUM_EN
                        state_d = ST_CHECK;
`else
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
`endif
                     end else if (wc_q == CAPACITY) begin
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_HUNT;
                     end else begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = full_word;
                        addr_d    = addr_q + ADDR_W'(1);
                        wc_d      = wc_q + WC_W'(1);
`ifdef BOOT_CHECKSUM_EN
                        csum_d    = csum_q ^ full_word[7:0] ^ full_word[15:8]
                                           ^ full_word[23:16] ^ full_word[31:24];
`endif
                     end
                  end
               endcase
            end
         end
         ST_CHECK: begin
`ifdef BOOT_CHECKSUM_EN
            if (tmo_expired) begin
               error_d = 1'b1;
               busy_d  = 1'b0;
               state_d = ST_HUNT;
            end else if (rx_valid) begin
               busy_d = 1'b0;
               if (rx_data == csum_q) begin
                  state_d = ST_DONE;
                  done_d  = 1'b1;
               end else begin
                  error_d = 1'b1;
                  state_d = ST_HUNT;
               end
            end
`else
            state_d = ST_HUNT;
`endif
         end
         default: begin
            state_d = ST_HUNT;
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_HUNT;
         hist_q    <= '0;
         word_q    <= '0;
         idx_q     <= '0;
         addr_q    <= '0;
         wc_q      <= '0;
         wr_en_q   <= 1'b0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         error_q   <= 1'b0;
`ifdef BOOT_CHECKSUM_EN
         csum_q    <= '0;
`endif
      end else begin
         state_q   <= state_d;
         hist_q    <= hist_d;
         word_q    <= word_d;
         idx_q     <= idx_d;
         addr_q    <= addr_d;
         wc_q      <= wc_d;
         wr_en_q   <= wr_en_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         error_q   <= error_d;
`ifdef BOOT_CHECKSUM_EN
         csum_q    <= csum_d;
`endif
      end
   end

   assign flash_wr_en   = wr_en_q;
   assign flash_wr_addr = wr_addr_q;
   assign flash_wr_data = wr_data_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign error         = error_q;
   assign word_count    = wc_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
// Self-checking bench for uart_boot_loader (small flash, short timeout).
// Also exercises the checksum path when BOOT_CHECKSUM_EN is defined.
module tb_uart_boot_loader;

   localparam int unsigned ADDR_W  = 2;
   localparam int unsigned TIMEOUT = 200;

   logic              clk;
   logic              reset;
   logic [7:0]        rx_data;
   logic              rx_valid;
   logic              flash_wr_en;
   logic [ADDR_W-1:0] flash_wr_addr;
   logic [31:0]       flash_wr_data;
   logic              busy;
   logic              done;
   logic              error;
   logic [ADDR_W:0]   word_count;

   uart_boot_loader #(
      .ADDR_W        (ADDR_W),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .flash_wr_en  (flash_wr_en),
      .flash_wr_addr(flash_wr_addr),
      .flash_wr_data(flash_wr_data),
      .busy         (busy),
      .done         (done),
      .error        (error),
      .word_count   (word_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [8*32-1:0] bytes;
      int              nbytes;
      logic [127:0]    words;
      int              nwords;
      bit              has_end;
      bit              exp_done;
      bit              exp_err;
      int              exp_wc;
   } vec_t;

   typedef struct {
      logic [ADDR_W-1:0] addr;
      logic [31:0]       data;
   } wr_t;

   vec_t vecs[6];
   wr_t  sb[$];
   int   checks;
   int   failures;
   int   done_cnt;
   bit   done_at_byte;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // One clock, then sample outputs and drain the write scoreboard.
   task automatic tick();
      wr_t e;
      @(posedge clk);
      #1;
      if (flash_wr_en) begin
         if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_write addr=%0d data=%h required=no_write",
                     flash_wr_addr, flash_wr_data);
         end else begin
            e = sb.pop_front();
            chk("wr_addr", 32'(flash_wr_addr), 32'(e.addr));
            chk("wr_data", flash_wr_data, e.data);
         end
      end
      if (done) done_cnt++;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      done_at_byte = done;
      rx_valid = 1'b0;
      rx_data  = 8'h00;
      tick();
   endtask

   task automatic apply_vec(input int i, input bit bad_csum);
      logic [31:0] w;
      logic [7:0]  cs;
      wr_t         e;
      bit          exp_done;
      bit          exp_err;
      done_cnt = 0;
      cs = 8'h00;
      for (int k = 0; k < vecs[i].nwords; k++) begin
         w = vecs[i].words[32*(vecs[i].nwords-1-k) +: 32];
         e.addr = ADDR_W'(k);
         e.data = w;
         sb.push_back(e);
         cs = cs ^ w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
      end
      for (int k = 0; k < vecs[i].nbytes; k++)
         send_byte(vecs[i].bytes[8*(vecs[i].nbytes-1-k) +: 8]);
      exp_done = vecs[i].exp_done;
      exp_err  = vecs[i].exp_err;
`ifdef BOOT_CHECKSUM_EN
      if (vecs[i].has_end) begin
         send_byte(bad_csum ? (cs ^ 8'h01) : cs);
         if (bad_csum) begin
            exp_done = 1'b0;
            exp_err  = 1'b1;
         end
      end
`endif
      if (vecs[i].has_end) chk($sformatf("v%0d_done_latency", i), 32'(done_at_byte), 32'(exp_done));
      repeat (3) tick();
      chk($sformatf("v%0d_done_pulses", i), 32'(done_cnt), 32'(exp_done));
      chk($sformatf("v%0d_error", i), 32'(error), 32'(exp_err));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'd0);
      chk($sformatf("v%0d_word_count", i), 32'(word_count), 32'(vecs[i].exp_wc));
      chk($sformatf("v%0d_writes_left", i), 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      done_cnt = 0;
      done_at_byte = 1'b0;
      reset    = 1'b1;
      rx_data  = 8'h00;
      rx_valid = 1'b0;

      // No start marker: bytes discarded.
      vecs[0] = '{bytes: 256'({8'h01,8'h02,8'h03,8'h04,8'h10,8'h20,8'h30,8'h40}), nbytes: 8,
                  words: 128'(0), nwords: 0, has_end: 1'b0,
                  exp_done: 1'b0, exp_err: 1'b0, exp_wc: 0};
      // Single word frame.
      vecs[1] = '{bytes: 256'({8'h5a,8'ha5,8'h0f,8'hf0, 8'h50,8'h60,8'h70,8'h80,
                               8'hf0,8'h0f,8'ha5,8'h5a}), nbytes: 12,
                  words: 128'(32'h80706050), nwords: 1, has_end: 1'b1,
                  exp_done: 1'b1, exp_err: 1'b0, exp_wc: 1};
      // Stray bytes ahead of the marker, four words filling the flash.
      vecs[2] = '{bytes: 256'({8'h70,8'h80, 8'h5a,8'ha5,8'h0f,8'hf0,
                               8'h11,8'h22,8'h33,8'h44, 8'h55,8'h66,8'h77,8'h88,
                               8'h99,8'haa,8'hbb,8'hcc, 8'hdd,8'hee,8'hff,8'h01,
                               8'hf0,8'h0f,8'ha5,8'h5a}), nbytes: 26,
                  words: 128'({32'h44332211,32'h88776655,32'hccbbaa99,32'h01ffeedd}), nwords: 4,
                  has_end: 1'b1, exp_done: 1'b1, exp_err: 1'b0, exp_wc: 4};
      // Five words into a four-word flash: fifth is dropped with error.
      vecs[3] = '{bytes: 256'({8'h5a,8'ha5,8'h0f,8'hf0,
                               8'h01,8'h02,8'h03,8'h04, 8'h05,8'h06,8'h07,8'h08,
                               8'h09,8'h0a,8'h0b,8'h0c, 8'h0d,8'h0e,8'h0f,8'h10,
                               8'h11,8'h12,8'h13,8'h14}), nbytes: 24,
                  words: 128'({32'h04030201,32'h08070605,32'h0c0b0a09,32'h100f0e0d}), nwords: 4,
                  has_end: 1'b0, exp_done: 1'b0, exp_err: 1'b1, exp_wc: 4};
      // Good frame after an error clears it.
      vecs[4] = '{bytes: 256'({8'h5a,8'ha5,8'h0f,8'hf0, 8'h0a,8'h0b,8'h0c,8'h0d,
                               8'hf0,8'h0f,8'ha5,8'h5a}), nbytes: 12,
                  words: 128'(32'h0d0c0b0a), nwords: 1, has_end: 1'b1,
                  exp_done: 1'b1, exp_err: 1'b0, exp_wc: 1};
      // Empty frame.
      vecs[5] = '{bytes: 256'({8'h5a,8'ha5,8'h0f,8'hf0, 8'hf0,8'h0f,8'ha5,8'h5a}), nbytes: 8,
                  words: 128'(0), nwords: 0, has_end: 1'b1,
                  exp_done: 1'b1, exp_err: 1'b0, exp_wc: 0};

      repeat (3) tick();
      chk("rst_wr_en", 32'(flash_wr_en), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_error", 32'(error), 32'd0);
      chk("rst_word_count", 32'(word_count), 32'd0);
      chk("rst_wr_data", flash_wr_data, 32'd0);
      reset = 1'b0;
      tick();

      for (int i = 0; i < 6; i++) apply_vec(i, 1'b0);

      // Timeout with a partial word pending.
      foreach (vecs[1].bytes[k]) begin end
      send_byte(8'h5a); send_byte(8'ha5); send_byte(8'h0f); send_byte(8'hf0);
      chk("tmo_busy_after_start", 32'(busy), 32'd1);
      send_byte(8'h50); send_byte(8'h60);
      repeat (150) tick();
      chk("tmo_error_early", 32'(error), 32'd0);
      begin
         int n;
         n = 0;
         while (!error && n < 400) begin
            tick();
            n++;
         end
         chk("tmo_bounded_wait", 32'(n < 400), 32'd1);
      end
      chk("tmo_error", 32'(error), 32'd1);
      chk("tmo_busy", 32'(busy), 32'd0);
      chk("tmo_no_write", 32'(sb.size()), 32'd0);
      apply_vec(4, 1'b0);

      // Reset mid-frame, then a fresh frame loads from address 0.
      begin
         wr_t e;
         e.addr = 2'd0; e.data = 32'h04030201; sb.push_back(e);
         e.addr = 2'd1; e.data = 32'h08070605; sb.push_back(e);
      end
      send_byte(8'h5a); send_byte(8'ha5); send_byte(8'h0f); send_byte(8'hf0);
      send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
      send_byte(8'h05); send_byte(8'h06); send_byte(8'h07); send_byte(8'h08);
      chk("mid_word_count", 32'(word_count), 32'd2);
      send_byte(8'h09); send_byte(8'h0a);
      reset = 1'b1;
      tick();
      chk("mid_rst_busy", 32'(busy), 32'd0);
      chk("mid_rst_word_count", 32'(word_count), 32'd0);
      chk("mid_rst_wr_en", 32'(flash_wr_en), 32'd0);
      chk("mid_rst_writes_left", 32'(sb.size()), 32'd0);
      reset = 1'b0;
      tick();
      apply_vec(1, 1'b0);

`ifdef BOOT_CHECKSUM_EN
      apply_vec(1, 1'b1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
